ascon_block_assembler: RTL and testbench

Collects a stream of 32-bit words into 128-bit Ascon-AEAD128 rate blocks for the permutation datapath: the reverse direction of the core's word-select output path, which narrows 128-bit state lanes to a 32-bit bus. Each word lands in its lane of the block. A partial final block is zero-filled and, when configured, receives Ascon 0x01 padding. The block sits between the host data interface and the absorb logic, with valid/ready handshakes on both sides.

---
 rtl/ascon_pkg.sv | 19 +
 rtl/byte_mask32.sv | 29 ++
 rtl/ascon_block_assembler.sv | 161 ++++++++++++++++
 tb/tb_ascon_block_assembler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg
//   Shared definitions for the Ascon block assembler.
//   state_e    : assembler FSM states (COLLECT, HOLD, PADBLK).
//   RATE_BYTES : AEAD128 rate block size in bytes.
//   WORD_BYTES : bytes per input word.
//   PAD_BYTE   : Ascon padding byte.
package ascon_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    PADBLK  = 2'd2
  } state_e;

  localparam int          RATE_BYTES = 16;
  localparam int          WORD_BYTES = 4;
  localparam logic [7:0]  PAD_BYTE   = 8'h01;

endpackage

// File: rtl/byte_mask32.sv
// byte_mask32
//   Combinational byte masker for one 32-bit little-endian word.
//   Bytes at or above nbytes are forced to 0x00; when pad_en is set the
//   byte at position nbytes (if it lies inside the word) becomes PAD_BYTE.
// Ports:
//   data   in  32  raw input word
//   nbytes in  3   number of valid low-order bytes (0..4)
//   pad_en in  1   insert PAD_BYTE at position nbytes
//   masked out 32  masked / padded word
module byte_mask32
  import ascon_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  input  logic        pad_en,
  output logic [31:0] masked
);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
      localparam logic [2:0] POS = 3'(gi);
      assign masked[8*gi +: 8] = (POS < nbytes)                ? data[8*gi +: 8] :
                                 (pad_en && (POS == nbytes))   ? PAD_BYTE        :
                                                                 8'h00;
    end
  endgenerate

endmodule

// File: rtl/ascon_block_assembler.sv
// ascon_block_assembler
//   Packs a stream of 32-bit words into 128-bit Ascon-AEAD128 rate blocks.
//   Word k of a block lands in out_data[32k+31:32k]. A short final block is
//   zero-filled. Optional macro ASCON_PAD_EN adds Ascon 0x01 padding and, after
//   a full 16-byte final block, an extra padding-only block.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clear                   synchronous abort of the partial/pending block
//   in_data/in_bytes/in_last/in_valid/in_ready   word-side handshake
//   out_data/out_bytes/out_last/out_valid/out_ready  block-side handshake
// All outputs are registered; out_data/out_bytes/out_last are the
// accumulator, byte count and last flag themselves.
module ascon_block_assembler
  import ascon_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic [4:0]   out_bytes,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [1:0] LAST_IDX = 2'(NWORDS - 1);

  state_e      state_reg;
  logic [1:0]  idx_reg;
  logic [1:0]  idx_inc;
  logic [2:0]  bytes_eff;
  logic [4:0]  count_next;
  logic [31:0] lane_word;
  logic        mask_pad;

  // Illegal in_bytes > 4 is clamped so the count cannot run away.
  assign bytes_eff  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign count_next = out_bytes + {2'b00, bytes_eff};
  assign idx_inc    = idx_reg + 2'd1;

`ifdef ASCON_PAD_EN
  logic pad_pending_reg;
  assign mask_pad = in_last;
`else
  assign mask_pad = 1'b0;
`endif

  byte_mask32 u_mask (
    .data   (in_data),
    .nbytes (bytes_eff),
    .pad_en (mask_pad),
    .masked (lane_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= COLLECT;
      idx_reg         <= 2'd0;
      out_data        <= '0;
      out_bytes       <= 5'd0;
      out_last        <= 1'b0;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
`ifdef ASCON_PAD_EN
      pad_pending_reg <= 1'b0;
`endif
    end else if (clear) begin
      state_reg       <= COLLECT;
      idx_reg         <= 2'd0;
      out_data        <= '0;
      out_bytes       <= 5'd0;
      out_last        <= 1'b0;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
`ifdef ASCON_PAD_EN
      pad_pending_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        COLLECT: begin
          if (in_valid) begin
            out_data[{idx_reg, 5'd0} +: 32] <= lane_word;
`ifdef ASCON_PAD_EN
            // A full last word that is not the 4th leaves the pad byte for
            // byte 0 of the following (otherwise zero) lane.
            if (in_last && (bytes_eff == 3'd4) && (idx_reg != LAST_IDX))
              out_data[{idx_inc, 5'd0} +: 32] <= 32'h0000_0001;
`endif
            out_bytes <= count_next;
            idx_reg   <= idx_inc;
            if ((idx_reg == LAST_IDX) || in_last) begin
              state_reg <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= in_last;
`ifdef ASCON_PAD_EN
              pad_pending_reg <= in_last && (count_next == 5'(RATE_BYTES));
`endif
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
`ifdef ASCON_PAD_EN
            if (pad_pending_reg) begin
              // Padding-only block: the registers become its outputs.
              state_reg       <= PADBLK;
              pad_pending_reg <= 1'b0;
              out_data        <= 128'h01;
              out_bytes       <= 5'd0;
              out_last        <= 1'b1;
            end else
`endif
            begin
              state_reg <= COLLECT;
              idx_reg   <= 2'd0;
              out_data  <= '0;
              out_bytes <= 5'd0;
              out_last  <= 1'b0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end

`ifdef ASCON_PAD_EN
        PADBLK: begin
          if (out_ready) begin
            state_reg <= COLLECT;
            idx_reg   <= 2'd0;
            out_data  <= '0;
            out_bytes <= 5'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg <= COLLECT;
          idx_reg   <= 2'd0;
          out_data  <= '0;
          out_bytes <= 5'd0;
          out_last  <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_block_assembler.sv
// tb_ascon_block_assembler
//   Directed self-checking bench for ascon_block_assembler. Expected values
//   are hand-computed; the ASCON_PAD_EN macro selects padded expectations.
module tb_ascon_block_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef ASCON_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  ascon_block_assembler #(.NWORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),  128'(1'b1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, "_out_last"},  128'(out_last),  128'(1'b0));
    check({tag, "_out_bytes"}, 128'(out_bytes), 128'(5'd0));
    check({tag, "_out_data"},  out_data,        128'h0);
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input string tag, input logic [31:0] d, input logic [2:0] b, input logic l);
    int n = 0;
    in_data  = d;
    in_bytes = b;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    $display("word  %s data=%h bytes=%0d last=%0b", tag, d, b, l);
  endtask

  // Wait (bounded) for a block, compare it, then consume it.
  task automatic expect_block(input string tag, input logic [127:0] d, input logic [4:0] b, input logic l);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    check({tag, "_data"},  out_data,        d);
    check({tag, "_bytes"}, 128'(out_bytes), 128'(b));
    check({tag, "_last"},  128'(out_last),  128'(l));
    $display("block %s data=%h bytes=%0d last=%0b", tag, out_data, out_bytes, out_last);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state, during and after reset
    tick();
    tick();
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_reset");

    // 1: four full words, valid one cycle after 4th accept
    send_word("t1w0", 32'h03020100, 3'd4, 1'b0);
    send_word("t1w1", 32'h07060504, 3'd4, 1'b0);
    send_word("t1w2", 32'h0B0A0908, 3'd4, 1'b0);
    send_word("t1w3", 32'h0F0E0D0C, 3'd4, 1'b0);
    check("t1_latency_valid", 128'(out_valid), 128'(1'b1));
    check("t1_hold_in_ready", 128'(in_ready),  128'(1'b0));
    expect_block("t1", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 5'd16, 1'b0);
    check("t1_back_in_ready", 128'(in_ready), 128'(1'b1));

    // 2: partial final block, garbage upper bytes must be masked
    send_word("t2w0", 32'h11223344, 3'd4, 1'b0);
    send_word("t2w1", 32'hFFFFFFAA, 3'd1, 1'b1);
    expect_block("t2", PAD ? 128'h00000000_00000000_000001AA_11223344
                           : 128'h00000000_00000000_000000AA_11223344, 5'd5, 1'b1);

    // 3: empty message
    send_word("t3w0", 32'hFFFFFFFF, 3'd0, 1'b1);
    expect_block("t3", PAD ? 128'h01 : 128'h00, 5'd0, 1'b1);

    // 4: full 16-byte final block
    send_word("t4w0", 32'h33221100, 3'd4, 1'b0);
    send_word("t4w1", 32'h77665544, 3'd4, 1'b0);
    send_word("t4w2", 32'hBBAA9988, 3'd4, 1'b0);
    send_word("t4w3", 32'hFFEEDDCC, 3'd4, 1'b1);
    expect_block("t4", 128'hFFEEDDCC_BBAA9988_77665544_33221100, 5'd16, 1'b1);
`ifdef ASCON_PAD_EN
    check("t4_padblk_valid", 128'(out_valid), 128'(1'b1));
    expect_block("t4pad", 128'h01, 5'd0, 1'b1);
`endif
    check("t4_done_valid",    128'(out_valid), 128'(1'b0));
    check("t4_done_in_ready", 128'(in_ready),  128'(1'b1));

    // 5: stall in HOLD for 10 cycles with the next word already offered
    send_word("t5w0", 32'hA0A1A2A3, 3'd4, 1'b0);
    send_word("t5w1", 32'hB0B1B2B3, 3'd4, 1'b1);
    in_data  = 32'hC0C1C2C3;
    in_bytes = 3'd4;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t5_stall_valid",    128'(out_valid), 128'(1'b1));
      check("t5_stall_in_ready", 128'(in_ready),  128'(1'b0));
      check("t5_stall_data", out_data,
            PAD ? 128'h00000000_00000001_B0B1B2B3_A0A1A2A3
                : 128'h00000000_00000000_B0B1B2B3_A0A1A2A3);
      tick();
    end
    in_valid = 1'b0;
    expect_block("t5", PAD ? 128'h00000000_00000001_B0B1B2B3_A0A1A2A3
                           : 128'h00000000_00000000_B0B1B2B3_A0A1A2A3, 5'd8, 1'b1);
    send_word("t5w2", 32'hC0C1C2C3, 3'd4, 1'b0);
    send_word("t5w3", 32'hFFFF5566, 3'd2, 1'b1);
    expect_block("t5next", PAD ? 128'h00000000_00000000_00015566_C0C1C2C3
                               : 128'h00000000_00000000_00005566_C0C1C2C3, 5'd6, 1'b1);

    // 6: clear after two words, with a word offered in the clear cycle
    send_word("t6w0", 32'h11111111, 3'd4, 1'b0);
    send_word("t6w1", 32'h22222222, 3'd4, 1'b0);
    clear    = 1'b1;
    in_data  = 32'h99999999;
    in_bytes = 3'd4;
    in_last  = 1'b0;
    in_valid = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_reset_outputs("t6_after_clear");
    send_word("t6w2", 32'hFFCCBBAA, 3'd3, 1'b1);
    expect_block("t6", PAD ? 128'h01CCBBAA : 128'h00CCBBAA, 5'd3, 1'b1);

    // 7: asynchronous reset while in HOLD
    send_word("t7w0", 32'hCAFEF00D, 3'd4, 1'b1);
    check("t7_hold_valid", 128'(out_valid), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    send_word("t7w1", 32'hFFFFBEEF, 3'd2, 1'b1);
    expect_block("t7", PAD ? 128'h0001BEEF : 128'h0000BEEF, 5'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
